// File: rtl/ddr5_phy_crc_sched.sv
// Write-CRC sequencer for BL16 bursts: feeds eight data bytes to the x4 CRC engine,
// appends the captured CRC byte to the output stream and aborts bursts that stall.
module ddr5_phy_crc_sched #(
  parameter int BEATS_PER_BURST = 8,
  parameter int GAP_TIMEOUT     = 15,
  parameter int TO_W            = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       crc_cfg_en_i,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  output logic       crc_en_o,
  output logic [7:0] crc_data_o,
  output logic       crc_rst_n_o,
  input  logic [7:0] crc_code_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_is_crc_o,
  output logic       out_last_o,
  output logic       err_timeout_o
);

  localparam int BEAT_W = $clog2(BEATS_PER_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS_PER_BURST - 1);
  localparam logic [TO_W-1:0]   GAP_LIMIT   = TO_W'(GAP_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CAP
  } state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic              crc_on_q, crc_on_d;
  logic              accept;
  logic              last_beat;
  logic              timeout;
  logic              crc_rst_n_q;
  logic              out_valid_q, out_is_crc_q, out_last_q;
  logic [7:0]        out_data_q;

  // Next-state and combinational outputs; reset forces every output low.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and a latch is never inferred.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    crc_on_d   = crc_on_q;
    accept     = 1'b0;
    last_beat  = 1'b0;
    timeout    = 1'b0;
    wr_ready_o = 1'b0;
    crc_en_o   = 1'b0;
    crc_data_o = 8'h00;

    if (!rst_i) begin
      unique case (state_q)
        S_IDLE: begin
          wr_ready_o = 1'b1;
          crc_data_o = wr_data_i;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          if (wr_valid_i) begin
            accept     = 1'b1;
            crc_en_o   = crc_cfg_en_i;
            crc_on_d   = crc_cfg_en_i;
            beat_cnt_d = BEAT_W'(1);
            state_d    = S_DATA;
          end
        end

        S_DATA: begin
          if (gap_cnt_q == GAP_LIMIT) begin
            // Stalled burst: drop it, the engine is cleared by crc_rst_n_o this cycle.
            timeout    = 1'b1;
            beat_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = S_IDLE;
          end else begin
            wr_ready_o = 1'b1;
            crc_data_o = wr_data_i;
            if (wr_valid_i) begin
              accept     = 1'b1;
              crc_en_o   = crc_on_q;
              gap_cnt_d  = '0;
              beat_cnt_d = beat_cnt_q + BEAT_W'(1);
              if (beat_cnt_q == LAST_BEAT) begin
                last_beat = 1'b1;
                state_d   = crc_on_q ? S_CAP : S_IDLE;
              end
            end else begin
              gap_cnt_d = gap_cnt_q + TO_W'(1);
            end
          end
        end

        S_CAP: begin
          // Ninth enable with zero data returns the engine's beat counter to 0.
          crc_en_o   = 1'b1;
          crc_data_o = 8'h00;
          beat_cnt_d = '0;
          state_d    = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      crc_on_q   <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      crc_on_q   <= crc_on_d;
    end
  end

  // Engine reset is pre-decoded so it is low exactly in the timeout cycle,
  // leaving the engine clean before the next first byte can be accepted.
  always_ff @(posedge clk_i) begin
    crc_rst_n_q <= ~rst_i & ~(gap_cnt_d == GAP_LIMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_is_crc_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= wr_data_i;
      out_is_crc_q <= 1'b0;
      out_last_q   <= last_beat & ~crc_on_q;
    end else if (state_q == S_CAP) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= crc_code_i;
      out_is_crc_q <= 1'b1;
      out_last_q   <= 1'b1;
    end else begin
      out_valid_q  <= 1'b0;
      out_is_crc_q <= 1'b0;
      out_last_q   <= 1'b0;
    end
  end

  assign crc_rst_n_o   = crc_rst_n_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_is_crc_o  = out_is_crc_q;
  assign out_last_o    = out_last_q;
  assign err_timeout_o = timeout;

endmodule

// File: tb/tb_ddr5_phy_crc_sched.sv
// Directed bench for ddr5_phy_crc_sched with a behavioural x4 CRC engine model
// (CRC-8, x^8+x^2+x+1, byte p bit b weighted by x^(8+8p+b)).
module tb_ddr5_phy_crc_sched;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       crc_cfg_en_i = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_ready_o;
  logic       crc_en_o;
  logic [7:0] crc_data_o;
  logic       crc_rst_n_o;
  logic [7:0] crc_code_i;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_is_crc_o;
  logic       out_last_o;
  logic       err_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  ddr5_phy_crc_sched dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .crc_cfg_en_i  (crc_cfg_en_i),
    .wr_valid_i    (wr_valid_i),
    .wr_data_i     (wr_data_i),
    .wr_ready_o    (wr_ready_o),
    .crc_en_o      (crc_en_o),
    .crc_data_o    (crc_data_o),
    .crc_rst_n_o   (crc_rst_n_o),
    .crc_code_i    (crc_code_i),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_is_crc_o  (out_is_crc_o),
    .out_last_o    (out_last_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- engine model ----------------
  function automatic logic [7:0] xpow(input int n);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < n; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] contrib(input logic [7:0] d, input int pos);
    logic [7:0] r = 8'h00;
    for (int b = 0; b < 8; b++) if (d[b]) r ^= xpow(8 + 8 * pos + b);
    return r;
  endfunction

  logic [7:0] eng_acc = 8'h00;
  int         eng_cnt = 0;

  always @(posedge clk_i) begin
    if (crc_rst_n_o === 1'b0) begin
      eng_acc <= 8'h00;
      eng_cnt <= 0;
    end else if (crc_en_o === 1'b1) begin
      if (eng_cnt == 8) begin
        eng_acc <= 8'h00;
        eng_cnt <= 0;
      end else begin
        eng_acc <= eng_acc ^ contrib(crc_data_o, eng_cnt);
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  assign crc_code_i = eng_acc;

  // ---------------- monitor ----------------
  logic [7:0] od_q[$];
  bit         oc_q[$];
  bit         ol_q[$];
  int         ot_q[$];
  int cyc = 0, n_en = 0, n_to = 0, n_rstlow = 0, n_rdylow = 0, t_to = -1, t_rstlow = -1;

  always @(negedge clk_i) begin
    cyc++;
    if (out_valid_o) begin
      od_q.push_back(out_data_o);
      oc_q.push_back(out_is_crc_o);
      ol_q.push_back(out_last_o);
      ot_q.push_back(cyc);
    end
    if (crc_en_o) n_en++;
    if (err_timeout_o) begin n_to++; t_to = cyc; end
    if (!crc_rst_n_o) begin n_rstlow++; t_rstlow = cyc; end
    if (!wr_ready_o) n_rdylow++;
  end

  task automatic clear_log();
    od_q.delete(); oc_q.delete(); ol_q.delete(); ot_q.delete();
    n_en = 0; n_to = 0; n_rstlow = 0; n_rdylow = 0; t_to = -1; t_rstlow = -1;
  endtask

  function automatic logic [7:0] od(input int i);
    return (i < od_q.size()) ? od_q[i] : 8'hxx;
  endfunction

  function automatic logic oc(input int i);
    return (i < oc_q.size()) ? oc_q[i] : 1'bx;
  endfunction

  function automatic logic ol(input int i);
    return (i < ol_q.size()) ? ol_q[i] : 1'bx;
  endfunction

  function automatic int ot(input int i);
    return (i < ot_q.size()) ? ot_q[i] : -1000;
  endfunction

  function automatic int count_crc();
    int n = 0;
    foreach (oc_q[i]) if (oc_q[i]) n++;
    return n;
  endfunction

  function automatic int count_last();
    int n = 0;
    foreach (ol_q[i]) if (ol_q[i]) n++;
    return n;
  endfunction

  // ---------------- checking and drive ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    wr_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  // Presents one byte until accepted; called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] d, input logic cfg);
    bit ok = 1'b0;
    int tries = 0;
    wr_valid_i   = 1'b1;
    wr_data_i    = d;
    crc_cfg_en_i = cfg;
    while (!ok && tries < 40) begin
      #1;
      ok = wr_ready_o;
      tick();
      tries++;
    end
    if (!ok) check("accept_bound", 32'(tries), 32'(0));
    wr_valid_i = 1'b0;
  endtask

  // Byte 0 of the burst is v[7:0]; crc_cfg_en_i is inverted after the first byte.
  task automatic burst(input logic [63:0] v, input logic cfg, input int nb,
                       input int pos_a, input int gap_a, input int pos_b, input int gap_b);
    for (int i = 0; i < nb; i++) begin
      send_byte(v[8*i +: 8], (i == 0) ? cfg : ~cfg);
      if (i + 1 == pos_a) idle(gap_a);
      if (i + 1 == pos_b) idle(gap_b);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({wr_ready_o, crc_en_o, crc_data_o, crc_rst_n_o, out_valid_o,
                out_data_o, out_is_crc_o, out_last_o, err_timeout_o});
  endfunction

  initial begin
    // Reset state and release timing.
    rst_i = 1'b1;
    wr_data_i = 8'h5a;
    repeat (3) tick();
    @(negedge clk_i);
    check("rst_outputs_zero", all_outs(), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("rdy_first_cycle", 32'(wr_ready_o), 32'h1);
    check("crc_rstn_hold", 32'(crc_rst_n_o), 32'h0);
    tick();
    check("crc_rstn_release", 32'(crc_rst_n_o), 32'h1);
    tick();

    // Burst 01,00x7 with CRC on.
    clear_log();
    burst(64'h01, 1'b1, 8, 0, 0, 0, 0);
    idle(4);
    check("b1_count", 32'(od_q.size()), 32'd9);
    check("b1_byte0", 32'(od(0)), 32'h01);
    check("b1_crc", 32'(od(8)), 32'h07);
    check("b1_is_crc", 32'({oc(7), oc(8)}), 32'b01);
    check("b1_last", 32'({ol(7), ol(8)}), 32'b01);
    check("b1_last_cnt", 32'(count_last()), 32'd1);
    check("b1_crc_follow", 32'(ot(8) - ot(7)), 32'd1);
    check("b1_en_cnt", 32'(n_en), 32'd9);

    // 00,01,00x6 then an all-zero burst back to back.
    clear_log();
    burst(64'h0100, 1'b1, 8, 0, 0, 0, 0);
    burst(64'h0, 1'b1, 8, 0, 0, 0, 0);
    idle(4);
    check("b2_count", 32'(od_q.size()), 32'd18);
    check("b2_crc_a", 32'(od(8)), 32'h15);
    check("b2_crc_b", 32'(od(17)), 32'h00);
    check("b2_is_crc_b", 32'(oc(17)), 32'h1);
    check("b2_b2b_gap", 32'(ot(9) - ot(8)), 32'd1);
    check("b2_rdy_low", 32'(n_rdylow), 32'd2);

    // CRC off: no engine enables, last flag on byte 8, ready never drops.
    clear_log();
    burst(64'h8877665544332211, 1'b0, 8, 0, 0, 0, 0);
    idle(4);
    check("off_count", 32'(od_q.size()), 32'd8);
    check("off_byte7", 32'(od(7)), 32'h88);
    check("off_last", 32'({ol(6), ol(7)}), 32'b01);
    check("off_no_crc", 32'(count_crc()), 32'd0);
    check("off_en_cnt", 32'(n_en), 32'd0);
    check("off_rdy_low", 32'(n_rdylow), 32'd0);

    // 3-cycle gaps after bytes 2 and 5.
    clear_log();
    burst(64'h01, 1'b1, 8, 2, 3, 5, 3);
    idle(4);
    check("gap_crc", 32'(od(8)), 32'h07);
    check("gap_count", 32'(od_q.size()), 32'd9);
    check("gap_no_timeout", 32'(n_to), 32'd0);

    // 14-cycle gap is one short of the abort threshold.
    clear_log();
    burst(64'h0100, 1'b1, 8, 3, 14, 0, 0);
    idle(4);
    check("gap14_crc", 32'(od(8)), 32'h15);
    check("gap14_no_timeout", 32'(n_to), 32'd0);

    // Stall after byte 4: abort, engine reset, then a clean burst.
    clear_log();
    burst(64'h04030201, 1'b1, 4, 0, 0, 0, 0);
    idle(20);
    check("to_pulse_cnt", 32'(n_to), 32'd1);
    check("to_at_16th_cycle", 32'(t_to - ot(3)), 32'd15);
    check("to_rstn_low_cnt", 32'(n_rstlow), 32'd1);
    check("to_rstn_aligned", 32'(t_rstlow - t_to), 32'd0);
    check("to_data_kept", 32'(od_q.size()), 32'd4);
    check("to_no_crc", 32'(count_crc()), 32'd0);
    clear_log();
    burst(64'h0100, 1'b1, 8, 0, 0, 0, 0);
    idle(4);
    check("to_next_crc", 32'(od(8)), 32'h15);

    // Reset after byte 6.
    clear_log();
    burst(64'hff_ee_dd_cc_bb_aa, 1'b1, 6, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_rst_outputs_zero", all_outs(), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(3);
    check("mid_rst_data_cnt", 32'(od_q.size()), 32'd6);
    check("mid_rst_no_crc", 32'(count_crc()), 32'd0);
    clear_log();
    burst(64'h01, 1'b1, 8, 0, 0, 0, 0);
    idle(4);
    check("post_rst_crc", 32'(od(8)), 32'h07);
    check("post_rst_is_crc", 32'({oc(8), ol(8)}), 32'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
